// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the btn_debounce pushbutton conditioner: FSM encoding
// and counter-width helper.
package btn_debounce_pkg;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } db_state_e;

   localparam int SYNC_STAGES = 2;

   // Bits needed to hold any value 0..n inclusive.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One debounce channel: 2-FF synchronizer, stability FSM, edge pulses and,
// when BTN_DEBOUNCE_HOLD_EN is defined, a one-shot long-press detector.
module btn_debounce_chan
   import btn_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef BTN_DEBOUNCE_HOLD_EN
  ,parameter int HOLD_CYCLES     = 100_000_000
`endif
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_btn,
   output logic o_pressed,
   output logic o_released,
   output logic o_held
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   db_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          btn_q, btn_d;
   logic          pressed_q, pressed_d;
   logic          released_q, released_d;
   logic          commit;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         state_q    <= ST_STABLE;
         cnt_q      <= '0;
         btn_q      <= 1'b0;
         pressed_q  <= 1'b0;
         released_q <= 1'b0;
      end else begin
         s1_q       <= i_btn;
         s2_q       <= s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         btn_q      <= btn_d;
         pressed_q  <= pressed_d;
         released_q <= released_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         ST_STABLE: begin
            if (s2_q != btn_q) begin
               // A one-cycle debounce accepts the very first differing sample.
               if (DEBOUNCE_CYCLES == 1) begin
                  commit = 1'b1;
               end else begin
                  state_d = ST_SETTLING;
                  cnt_d   = CNT_ONE;
               end
            end else begin
               cnt_d = '0;
            end
         end
         ST_SETTLING: begin
            if (s2_q == btn_q) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               commit = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
      if (commit) begin
         state_d = ST_STABLE;
         cnt_d   = '0;
      end
   end

   assign btn_d      = commit ? s2_q : btn_q;
   assign pressed_d  = commit &  s2_q;
   assign released_d = commit & ~s2_q;

   assign o_btn      = btn_q;
   assign o_pressed  = pressed_q;
   assign o_released = released_q;

`ifdef BTN_DEBOUNCE_HOLD_EN
   localparam int            HW        = cnt_width(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);

   logic [HW-1:0] hold_q, hold_d;
   logic          held_q, held_d;

   // Counter parks at HOLD_CYCLES so the pulse fires once per press.
   always_comb begin
      hold_d = hold_q;
      held_d = 1'b0;
      if (commit) begin
         hold_d = '0;
      end else if (btn_q && (hold_q != HOLD_LAST)) begin
         hold_d = hold_q + HW'(1);
         held_d = (hold_d == HOLD_LAST);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         hold_q <= '0;
         held_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         held_q <= held_d;
      end
   end

   assign o_held = held_q;
`else
   assign o_held = 1'b0;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel pushbutton conditioner: NBTN independent debounce channels.
// Long-press pulses on o_held exist only when BTN_DEBOUNCE_HOLD_EN is defined.
module btn_debounce
   import btn_debounce_pkg::*;
#(
   parameter int NBTN            = 8,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 100_000_000
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [NBTN-1:0] i_btn,
   output logic [NBTN-1:0] o_btn,
   output logic [NBTN-1:0] o_pressed,
   output logic [NBTN-1:0] o_released,
   output logic [NBTN-1:0] o_held
);

   // Marks an out-of-range configuration in the elaborated hierarchy.
   if ((DEBOUNCE_CYCLES < 1) || (HOLD_CYCLES < 1)) begin : g_invalid_cycle_params
   end

   for (genvar gi = 0; gi < NBTN; gi++) begin : g_chan
      btn_debounce_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_DEBOUNCE_HOLD_EN
        ,.HOLD_CYCLES    (HOLD_CYCLES)
`endif
      ) u_chan (
         .i_clk      (i_clk),
         .i_reset    (i_reset),
         .i_btn      (i_btn[gi]),
         .o_btn      (o_btn[gi]),
         .o_pressed  (o_pressed[gi]),
         .o_released (o_released[gi]),
         .o_held     (o_held[gi])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: window-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_btn_debounce;

   localparam int N  = 4;
   localparam int DC = 4;
   localparam int HC = 16;
`ifdef BTN_DEBOUNCE_HOLD_EN
   localparam bit HOLD_ON = 1'b1;
`else
   localparam bit HOLD_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn = '0;
   logic [N-1:0] o_btn, o_pr, o_rl, o_held;

   int vectors     = 0;
   int miscompares = 0;
   bit cmp_en      = 1'b0;

   btn_debounce #(.NBTN(N), .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .i_btn      (btn),
      .o_btn      (o_btn),
      .o_pressed  (o_pr),
      .o_released (o_rl),
      .o_held     (o_held)
   );

   always #5 clk = ~clk;

   // Reference model: o_btn flips when the synchronized level has differed
   // from it on each of the last DC clock edges.
   logic [N-1:0] m_s1, m_s2, m_btn, m_pr, m_rl, m_held;
   logic [N-1:0] win [DC];
   int           since [N];

   function automatic logic want_flip(int k);
      logic f = (m_s2[k] != m_btn[k]);
      for (int i = 0; i < DC - 1; i++)
         if (win[i][k] == m_btn[k]) f = 1'b0;
      return f;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_s1 <= '0; m_s2 <= '0; m_btn <= '0;
         m_pr <= '0; m_rl <= '0; m_held <= '0;
         for (int i = 0; i < DC; i++) win[i] <= '0;
         for (int k = 0; k < N; k++) since[k] <= -1;
      end else begin
         m_s1   <= btn;
         m_s2   <= m_s1;
         win[0] <= m_s2;
         for (int i = 1; i < DC; i++) win[i] <= win[i-1];
         for (int k = 0; k < N; k++) begin
            if (want_flip(k)) begin
               m_btn[k]  <= ~m_btn[k];
               m_pr[k]   <= ~m_btn[k];
               m_rl[k]   <= m_btn[k];
               m_held[k] <= 1'b0;
               since[k]  <= m_btn[k] ? -1 : 0;
            end else begin
               m_pr[k] <= 1'b0;
               m_rl[k] <= 1'b0;
               if (m_btn[k] && since[k] >= 0 && since[k] < HC) since[k] <= since[k] + 1;
               m_held[k] <= HOLD_ON && m_btn[k] && (since[k] == HC - 1);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         vectors++;
         if ({o_btn, o_pr, o_rl, o_held} !== {m_btn, m_pr, m_rl, m_held}) begin
            miscompares++;
            $display("FAIL model t=%0t btn/pr/rl/held got %b/%b/%b/%b expected %b/%b/%b/%b",
                     $time, o_btn, o_pr, o_rl, o_held, m_btn, m_pr, m_rl, m_held);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
      end else begin
         $display("ok   %s t=%0t value %0h", name, $time, act);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [N-1:0] v);
      @(negedge clk);
      btn = v;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t simulation did not finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int held_cnt;
      int held_at;
      logic [N-1:0] bounce [5];
      bounce[0] = 4'b0011; bounce[1] = 4'b0001; bounce[2] = 4'b0011;
      bounce[3] = 4'b0001; bounce[4] = 4'b0011;

      tick(3);
      cmp_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_state", {o_btn, o_pr, o_rl, o_held}, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_zero", {o_btn, o_pr, o_rl, o_held}, 0);
      end

      // Channel 0 press: commit at t0+5.
      drive(4'b0001); tick();
      tick(4); chk("press0_t0+4_btn", o_btn, 4'b0000);
      tick();  chk("press0_t0+5_btn", o_btn, 4'b0001);
               chk("press0_pulse", o_pr, 4'b0001);
      tick();  chk("press0_pulse_end", o_pr, 4'b0000);

      // Channel 1 bounce 1,0,1,0,1 then holds 1.
      for (int i = 0; i < 5; i++) begin
         drive(bounce[i]); tick();
         chk("bounce_no_pulse", {o_pr, o_rl}, 0);
      end
      tick(4); chk("bounce_t0+4_btn", o_btn, 4'b0001);
               chk("bounce_no_pulse", {o_pr, o_rl}, 0);
      tick();  chk("bounce_t0+5_btn", o_btn, 4'b0011);
               chk("bounce_press1", o_pr, 4'b0010);

      // Channel 0 release.
      drive(4'b0010); tick();
      tick(4); chk("rel0_t0+4_btn", o_btn, 4'b0011);
               chk("rel0_t0+4_rl", o_rl, 4'b0000);
      tick();  chk("rel0_t0+5_btn", o_btn, 4'b0010);
               chk("rel0_pulse", o_rl, 4'b0001);
               chk("rel0_no_press", o_pr, 4'b0000);
      tick();  chk("rel0_pulse_end", o_rl, 4'b0000);

      // Simultaneous presses on 2,3 with release of 1, then long hold.
      drive(4'b1100); tick();
      tick(4); chk("multi_t0+4_pr", o_pr, 4'b0000);
      tick();  chk("multi_pr", o_pr, 4'b1100);
               chk("multi_rl", o_rl, 4'b0010);
               chk("multi_btn", o_btn, 4'b1100);
      held_cnt = 0;
      held_at  = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (o_held[2]) begin
            held_cnt++;
            held_at = i;
         end
      end
      chk("held2_count", held_cnt, HOLD_ON ? 1 : 0);
      chk("held2_delay", held_at, HOLD_ON ? HC : -1);

      // Reset two cycles into SETTLING on channel 0; button stays held.
      drive(4'b1101); tick();
      tick(3);
      #2 rst = 1'b1;
      #1 chk("reset_immediate", {o_btn, o_pr, o_rl, o_held}, 0);
      tick(2);
      @(negedge clk);
      rst = 1'b0;
      tick();
      tick(4); chk("post_reset_t0+4", {o_btn, o_pr, o_rl}, 0);
      tick();  chk("post_reset_btn", o_btn, 4'b1101);
               chk("post_reset_press", o_pr, 4'b1101);

      // Randomized phase with alternating bounce intensity and rare resets.
      for (int c = 0; c < 3000; c++) begin
         int rng;
         rng = ((c / 200) % 2 == 0) ? 3 : 40;
         @(negedge clk);
         rst = 1'b0;
         for (int k = 0; k < N; k++)
            if ($urandom_range(0, rng - 1) == 0) btn[k] = ~btn[k];
         if ($urandom_range(0, 699) == 0) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
